// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (read-only) and load/store (read/write) requesters. One transaction is
// outstanding at a time. The winning request is latched on accept, driven to
// memory, and the memory response is routed back to the requester that owns it.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin arbitration on ties (IFU wins the first tie
//               after reset)
//   undefined - fixed priority, LSU always wins ties
//
// Ports:
//   clock, reset (async, active-low)
//   ifu_req_*  : fetch request (valid/ready/addr)
//   ifu_resp_* : fetch response (valid/data)
//   lsu_req_*  : load/store request (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_* : load/store response (valid/data, data is 0 for writes)
//   mem_req_*  : request to memory (valid/ready/addr/wen/wdata/wmask)
//   mem_resp_* : response from memory (valid/data)
//   busy       : a transaction is in flight (state is not IDLE)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic                  busy
);

    localparam int unsigned MASK_W = DATA_W / 8;

    // Owner / grant encoding: 0 = IFU, 1 = LSU.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    logic                accept;
    logic                grant_lsu;
    logic                tie_lsu;
    logic                lsu_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_grant_q;

    // On a tie, grant whichever requester was not granted last time.
    assign tie_lsu = (last_grant_q == OWN_IFU);

    // Reset value LSU makes IFU win the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= OWN_LSU;
        end else if (accept) begin
            last_grant_q <= grant_lsu;
        end
    end
`else
    // Fixed priority: LSU always wins a tie.
    assign tie_lsu = 1'b1;
`endif

    assign lsu_wins = lsu_req_valid && (!ifu_req_valid || tie_lsu);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant and handshake generation.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        grant_lsu      = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gating with reset keeps ready low while reset is held.
                if (reset && (ifu_req_valid || lsu_req_valid)) begin
                    accept        = 1'b1;
                    grant_lsu     = lsu_wins;
                    ifu_req_ready = !lsu_wins;
                    lsu_req_ready = lsu_wins;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                    end else begin
                        ifu_resp_valid = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch; IFU requests are always reads with an empty mask.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            owner_q <= grant_lsu;
            addr_q  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
            wen_q   <= grant_lsu & lsu_req_wen;
            wdata_q <= grant_lsu ? lsu_req_wdata : '0;
            wmask_q <= grant_lsu ? lsu_req_wmask : '0;
        end
    end

    // Memory request fields read as 0 whenever no request is presented.
    assign mem_req_addr  = mem_req_valid ? addr_q  : '0;
    assign mem_req_wen   = mem_req_valid & wen_q;
    assign mem_req_wdata = mem_req_valid ? wdata_q : '0;
    assign mem_req_wmask = mem_req_valid ? wmask_q : '0;

    // Response data passes through only to the owner; writes return 0.
    assign ifu_resp_data = ifu_resp_valid ? mem_resp_data : '0;
    assign lsu_resp_data = (lsu_resp_valid && !wen_q) ? mem_resp_data : '0;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

    logic         clock;
    logic         reset;
    logic         ifu_req_valid;
    logic         ifu_req_ready;
    logic [63:0]  ifu_req_addr;
    logic         ifu_resp_valid;
    logic [63:0]  ifu_resp_data;
    logic         lsu_req_valid;
    logic         lsu_req_ready;
    logic [63:0]  lsu_req_addr;
    logic         lsu_req_wen;
    logic [63:0]  lsu_req_wdata;
    logic [7:0]   lsu_req_wmask;
    logic         lsu_resp_valid;
    logic [63:0]  lsu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_req_addr;
    logic         mem_req_wen;
    logic [63:0]  mem_req_wdata;
    logic [7:0]   mem_req_wmask;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;
    logic         busy;

    int tests;
    int fails;

    logic [270:0] all_outs;
    assign all_outs = {ifu_req_ready, ifu_resp_valid, ifu_resp_data,
                       lsu_req_ready, lsu_resp_valid, lsu_resp_data,
                       mem_req_valid, mem_req_addr, mem_req_wen,
                       mem_req_wdata, mem_req_wmask, busy};

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [63:0] junk;
        clear_inputs();
        reset = 1'b0;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        tests++;
        if (all_outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        // LSU read taken to WAIT, then reset arrives.
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 64'h40;
        @(negedge clock);
        tests++;
        if (lsu_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_lsu_accept: got %b required 1", lsu_req_ready);
        end
        next_cycle();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        @(negedge clock);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_wait_busy: got %b required 1", busy);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (all_outs !== '0) begin
            fails++;
            $display("FAIL reset_midwait_outputs: got %h required 0", all_outs);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: busy got %b required 0", busy);
        end
        next_cycle();
        next_cycle();
        junk = {$urandom, $urandom};
        mem_resp_valid = 1'b1;
        mem_resp_data  = junk;
        @(negedge clock);
        tests++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_late_resp_dropped: resp/busy got %b required 000",
                     {ifu_resp_valid, lsu_resp_valid, busy});
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_ifu_read();
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h0000_0000_8000_0000;
        @(negedge clock);
        tests++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL ifu_accept: ready ifu/lsu got %b required 10",
                     {ifu_req_ready, lsu_req_ready});
        end
        next_cycle();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        tests++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !==
            {1'b1, 64'h0000_0000_8000_0000, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL ifu_mem_req: got v=%b a=%h w=%b m=%h required v=1 a=80000000 w=0 m=00",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        next_cycle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0000_0013_0000_0413;
        @(negedge clock);
        tests++;
        if ({ifu_resp_valid, ifu_resp_data, lsu_resp_valid} !==
            {1'b1, 64'h0000_0013_0000_0413, 1'b0}) begin
            fails++;
            $display("FAIL ifu_resp: got v=%b d=%h lsu_v=%b required v=1 d=0000001300000413 lsu_v=0",
                     ifu_resp_valid, ifu_resp_data, lsu_resp_valid);
        end
        next_cycle();
        clear_inputs();
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ifu_back_to_idle: busy got %b required 0", busy);
        end
        next_cycle();
    endtask

    task automatic test_lsu_write_stall();
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 64'h0000_0000_8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 64'h0000_0000_DEAD_BEEF;
        lsu_req_wmask = 8'h0F;
        @(negedge clock);
        tests++;
        if (lsu_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL lsu_w_accept: got %b required 1", lsu_req_ready);
        end
        next_cycle();
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            mem_req_ready = (c == 4);
            @(negedge clock);
            tests++;
            if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
                {1'b1, 64'h0000_0000_8000_1000, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F}) begin
                fails++;
                $display("FAIL lsu_w_stable c%0d: got v=%b a=%h w=%b d=%h m=%h", c,
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
            end
            next_cycle();
        end
        mem_req_ready = 1'b0;
        @(negedge clock);
        tests++;
        if ({mem_req_valid, mem_req_addr, lsu_resp_valid} !== {1'b0, 64'h0, 1'b0}) begin
            fails++;
            $display("FAIL lsu_w_wait_quiet: got v=%b a=%h rv=%b required 0/0/0",
                     mem_req_valid, mem_req_addr, lsu_resp_valid);
        end
        next_cycle();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h1234_5678_9ABC_DEF0;
        @(negedge clock);
        tests++;
        if ({lsu_resp_valid, lsu_resp_data, ifu_resp_valid} !== {1'b1, 64'h0, 1'b0}) begin
            fails++;
            $display("FAIL lsu_w_ack: got v=%b d=%h ifu_v=%b required v=1 d=0 ifu_v=0",
                     lsu_resp_valid, lsu_resp_data, ifu_resp_valid);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_tie();
        int grant;
        int exp_grant;
        int ifu_ready_seen;
        do_reset();
        ifu_ready_seen = 0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h100;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 64'h200;
        for (int t = 0; t < 6; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_grant = (t % 2 == 0) ? 1 : 2;
`else
            exp_grant = 2;
`endif
            @(negedge clock);
            grant = lsu_req_ready ? 2 : (ifu_req_ready ? 1 : 0);
            if (ifu_req_ready) ifu_ready_seen++;
            tests++;
            if (grant !== exp_grant) begin
                fails++;
                $display("FAIL tie_grant t%0d: got %0d required %0d (1=IFU 2=LSU)", t, grant, exp_grant);
            end
            next_cycle();
            mem_req_ready = 1'b1;
            @(negedge clock);
            tests++;
            if (mem_req_addr !== ((exp_grant == 2) ? 64'h200 : 64'h100)) begin
                fails++;
                $display("FAIL tie_addr t%0d: got %h", t, mem_req_addr);
            end
            next_cycle();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'(t);
            next_cycle();
            mem_resp_valid = 1'b0;
        end
`ifndef MEM_ARB_ROUND_ROBIN_EN
        tests++;
        if (ifu_ready_seen !== 0) begin
            fails++;
            $display("FAIL tie_ifu_starved: ifu_req_ready seen %0d times required 0", ifu_ready_seen);
        end
`endif
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_spurious_resp();
        do_reset();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hAAAA;
        @(negedge clock);
        tests++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL spur_idle: got %b required 000", {ifu_resp_valid, lsu_resp_valid, busy});
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 64'h88;
        next_cycle();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clock);
        tests++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b001) begin
            fails++;
            $display("FAIL spur_req: got %b required 001", {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        @(negedge clock);
        tests++;
        if (mem_req_valid !== 1'b1) begin
            fails++;
            $display("FAIL spur_still_req: got %b required 1", mem_req_valid);
        end
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hCAFE_F00D;
        @(negedge clock);
        tests++;
        if ({ifu_resp_valid, ifu_resp_data, lsu_resp_valid} !== {1'b1, 64'hCAFE_F00D, 1'b0}) begin
            fails++;
            $display("FAIL spur_wait_route: got v=%b d=%h lsu_v=%b", ifu_resp_valid, ifu_resp_data, lsu_resp_valid);
        end
        next_cycle();
        clear_inputs();
    endtask

    // Randomized run against a transaction-level model of the arbiter.
    task automatic test_random();
        int          phase;      // 0 idle, 1 request presented, 2 awaiting response
        int          next_phase;
        logic        own_lsu;
        logic        last_lsu;
        logic [63:0] t_addr, t_wdata;
        logic        t_wen;
        logic [7:0]  t_wmask;
        logic        e_ifu_rdy, e_lsu_rdy, e_mreq, e_ifu_rv, e_lsu_rv;
        logic [63:0] e_ifu_rd, e_lsu_rd;
        logic        tie_lsu;
        do_reset();
        phase    = 0;
        own_lsu  = 1'b0;
        last_lsu = 1'b1;
        t_addr = '0; t_wdata = '0; t_wen = 1'b0; t_wmask = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!ifu_req_valid && ($urandom % 3 == 0)) begin
                ifu_req_valid = 1'b1;
                ifu_req_addr  = {$urandom, $urandom} & ~64'h7;
            end
            if (!lsu_req_valid && ($urandom % 3 == 0)) begin
                lsu_req_valid = 1'b1;
                lsu_req_addr  = {$urandom, $urandom};
                lsu_req_wen   = 1'($urandom % 2);
                lsu_req_wdata = {$urandom, $urandom};
                lsu_req_wmask = 8'($urandom);
            end
            mem_req_ready  = 1'($urandom % 2);
            mem_resp_valid = ($urandom % 3 == 0);
            mem_resp_data  = {$urandom, $urandom};

            e_ifu_rdy = 1'b0; e_lsu_rdy = 1'b0; e_mreq = 1'b0;
            e_ifu_rv = 1'b0; e_lsu_rv = 1'b0; e_ifu_rd = '0; e_lsu_rd = '0;
            next_phase = phase;
            if (phase == 0) begin
                if (ifu_req_valid || lsu_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    tie_lsu = !last_lsu;
`else
                    tie_lsu = 1'b1;
`endif
                    own_lsu   = lsu_req_valid && (!ifu_req_valid || tie_lsu);
                    last_lsu  = own_lsu;
                    e_lsu_rdy = own_lsu;
                    e_ifu_rdy = !own_lsu;
                    t_addr  = own_lsu ? lsu_req_addr : ifu_req_addr;
                    t_wen   = own_lsu && lsu_req_wen;
                    t_wdata = own_lsu ? lsu_req_wdata : 64'h0;
                    t_wmask = own_lsu ? lsu_req_wmask : 8'h0;
                    next_phase = 1;
                end
            end else if (phase == 1) begin
                e_mreq = 1'b1;
                if (mem_req_ready) next_phase = 2;
            end else begin
                if (mem_resp_valid) begin
                    if (own_lsu) begin
                        e_lsu_rv = 1'b1;
                        e_lsu_rd = t_wen ? 64'h0 : mem_resp_data;
                    end else begin
                        e_ifu_rv = 1'b1;
                        e_ifu_rd = mem_resp_data;
                    end
                    next_phase = 0;
                end
            end

            @(negedge clock);
            tests++;
            if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy} !==
                {e_ifu_rdy, e_lsu_rdy, e_mreq, e_ifu_rv, e_lsu_rv, (phase != 0)}) begin
                fails++;
                $display("FAIL rand_ctrl cyc%0d: got %b required %b", cyc,
                         {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy},
                         {e_ifu_rdy, e_lsu_rdy, e_mreq, e_ifu_rv, e_lsu_rv, (phase != 0)});
            end
            tests++;
            if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
                (e_mreq ? {t_addr, t_wen, t_wdata, t_wmask} : 137'h0)) begin
                fails++;
                $display("FAIL rand_memreq cyc%0d: got a=%h w=%b d=%h m=%h required a=%h w=%b d=%h m=%h",
                         cyc, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
                         e_mreq ? t_addr : 64'h0, e_mreq && t_wen, e_mreq ? t_wdata : 64'h0,
                         e_mreq ? t_wmask : 8'h0);
            end
            tests++;
            if ({ifu_resp_data, lsu_resp_data} !== {e_ifu_rd, e_lsu_rd}) begin
                fails++;
                $display("FAIL rand_resp cyc%0d: got ifu=%h lsu=%h required ifu=%h lsu=%h",
                         cyc, ifu_resp_data, lsu_resp_data, e_ifu_rd, e_lsu_rd);
            end

            next_cycle();
            if (e_ifu_rdy) ifu_req_valid = 1'b0;
            if (e_lsu_rdy) lsu_req_valid = 1'b0;
            phase = next_phase;
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_lsu_write_stall();
        test_tie();
        test_spurious_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
